// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//            MULDIV_FAST_MUL_EN selects a single-cycle combinational multiply.
// Revision : 1.0
// ============================================================================
module muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi_we,
    input  logic            mtlo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(XLEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_isdiv;
    logic              r_sa;
    logic              r_sb;
    logic              r_dz;
    logic              r_done;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    // Shared accumulator: {partial product} for multiply, {remainder, quotient} for divide.
    logic [2*XLEN-1:0] r_p;

    logic              w_rs_neg;
    logic              w_rt_neg;
    logic [XLEN-1:0]   w_rs_mag;
    logic [XLEN-1:0]   w_rt_mag;
    logic [XLEN:0]     w_mul_add;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic              w_fast;
    logic [2*XLEN-1:0] w_fast_prod;

    assign w_rs_neg = op[0] & rs_val[XLEN-1];
    assign w_rt_neg = op[0] & rt_val[XLEN-1];
    assign w_rs_mag = w_rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign w_rt_mag = w_rt_neg ? (~rt_val + 1'b1) : rt_val;

`ifdef MULDIV_FAST_MUL_EN
    assign w_fast      = ~op[1];
    assign w_fast_prod = {{XLEN{1'b0}}, w_rs_mag} * {{XLEN{1'b0}}, w_rt_mag};
`else
    assign w_fast      = 1'b0;
    assign w_fast_prod = '0;
`endif

    assign w_mul_add   = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_div_shift = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};

    assign w_prod_fix = (r_sa ^ r_sb) ? (~r_p + 1'b1) : r_p;
    assign w_quo_fix  = (r_sa ^ r_sb) ? (~r_p[XLEN-1:0] + 1'b1) : r_p[XLEN-1:0];
    assign w_rem_fix  = r_sa ? (~r_p[2*XLEN-1:XLEN] + 1'b1) : r_p[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_fast ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == c_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_isdiv <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (mthi_we) r_hi <= wdata;
                    if (mtlo_we) r_lo <= wdata;
                    if (start) begin
                        r_isdiv <= op[1];
                        r_sa    <= w_rs_neg;
                        r_sb    <= w_rt_neg;
                        r_dz    <= (rt_val == '0);
                        r_a     <= w_rs_mag;
                        r_b     <= w_rt_mag;
                        r_cnt   <= '0;
                        if (w_fast)     r_p <= w_fast_prod;
                        else if (op[1]) r_p <= {{XLEN{1'b0}}, w_rs_mag};
                        else            r_p <= '0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_isdiv) begin
                        // Restore (keep shifted value) when the trial subtract goes negative.
                        if (w_div_diff[XLEN])
                            r_p <= {w_div_shift[XLEN-1:0], r_p[XLEN-2:0], 1'b0};
                        else
                            r_p <= {w_div_diff[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
                    end else begin
                        r_p <= {w_mul_add, r_p[XLEN-1:1]};
                        r_b <= r_b >> 1;
                    end
                end
                S_FIX: begin
                    if (r_isdiv) begin
                        // A zero divisor leaves the dividend in the remainder, so only LO is forced.
                        r_lo <= r_dz ? '1 : w_quo_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                        r_lo <= w_prod_fix[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Purpose  : Directed self-checking bench for muldiv_ctrl.
// Revision : 1.0
// ============================================================================
module tb_muldiv_ctrl;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit c_fast = 1'b1;
`else
    localparam bit c_fast = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_err;
    int n_checks;

    muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an idle cycle T; returns in cycle T+latency+1.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        logic bad;
        lat = (c_fast && !o[1]) ? 2 : 34;
        bad = 1'b0;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        for (int n = 1; n < lat; n++) begin
            step();
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
        end
        chk({tag, " busy window"}, {31'd0, bad}, 32'd0);
        step();
        chk({tag, " done"}, {30'd0, busy, done}, 32'd1);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
        step();
        chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic bad;
        n_err = 0; n_checks = 0;
        rst = 1'b1; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
        mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
        step(); step();
        chk("reset busy/done", {30'd0, busy, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst = 1'b0;
        step();

        do_op("MULTU ffff*ffff", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("MULT -3*7",       2'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("MULT min*min",    2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        do_op("MULTU 5*6",       2'd0, 32'd5,        32'd6,        32'h00000000, 32'd30);
        do_op("DIVU 100/7",      2'd2, 32'd100,      32'd7,        32'd2,        32'd14);
        do_op("DIV -7/2",        2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("DIV 7/-2",        2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        do_op("DIVU x/0",        2'd2, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
        do_op("DIV -7/0",        2'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
        do_op("DIV min/-1",      2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // Restart and MTHI while busy must both be ignored.
        bad = 1'b0;
        op = 2'd2; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        for (int n = 1; n < 34; n++) begin
            step();
            start = 1'b0;
            if (n == 5) begin
                start = 1'b1; rs_val = 32'd9; rt_val = 32'd4;
            end
            if (n == 6) begin
                mthi_we = 1'b1; wdata = 32'hAAAA5555;
            end
            if (n == 7) mthi_we = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
        end
        chk("busy ignore window", {31'd0, bad}, 32'd0);
        step();
        chk("busy ignore done", {30'd0, busy, done}, 32'd1);
        chk("busy ignore hi", hi, 32'd2);
        chk("busy ignore lo", lo, 32'd14);
        step();
        chk("busy ignore done pulse", {31'd0, done}, 32'd0);
        mtlo_we = 1'b1; wdata = 32'h00001234;
        step();
        mtlo_we = 1'b0;
        chk("mtlo lo", lo, 32'h00001234);
        chk("mtlo hi kept", hi, 32'd2);

        // Abort by reset mid-operation, then a clean restart.
        bad = 1'b0;
        op = c_fast ? 2'd3 : 2'd1; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            start = 1'b0;
            if (n == 10) rst = 1'b1;
            if (done !== 1'b0) bad = 1'b1;
        end
        step();
        rst = 1'b0;
        chk("abort busy/done", {30'd0, busy, done}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort no early done", {31'd0, bad}, 32'd0);
        step();
        do_op("after abort", 2'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS32 core.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles using a shift-add multiplier and a restoring divider.
- Exposes a busy flag so the pipeline hazard logic can stall MFHI/MFLO and any further mul/div issue.
- Sits beside the single-cycle ALU in EX and handles MTHI/MTLO writes.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits.
- CNT_W, 6, iteration counter width; must be at least clog2(XLEN)+1.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  issue strobe; sampled only in IDLE.
- op  input  2  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
- rs_val  input  XLEN  multiplicand / dividend.
- rt_val  input  XLEN  multiplier / divisor.
- mthi_we  input  1  write wdata into HI.
- mtlo_we  input  1  write wdata into LO.
- wdata  input  XLEN  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  single-cycle pulse; new HI/LO are valid in this cycle.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset (synchronous, rst high at a clock edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand registers cleared. Reset overrides every other input.
- States and transitions:
  - IDLE -> CALC when start=1. Latch op, sign flags and operand magnitudes. Signed ops use the two's-complement absolute value; abs(0x80000000)=0x80000000 taken as unsigned.
  - CALC: one iteration per cycle, XLEN iterations, counter 0..XLEN-1. CALC -> FIX after the last iteration.
  - Multiply iteration: 64-bit shift-add.
  - Divide iteration: restoring shift-subtract, producing quotient and remainder magnitudes.
  - FIX: apply signs. Product is negated if the operand signs differ. Quotient is negated if the signs differ; remainder takes the dividend's sign. Write hi/lo at the end of this cycle. FIX -> IDLE.
- Timing, with start sampled in cycle T:
  - busy=1 in cycles T+1 to T+XLEN+1.
  - hi/lo updated and done=1 in cycle T+XLEN+2 (T+34 at default).
  - busy and done are never both 1.
- Results:
  - MULT/MULTU: hi = product[63:32], lo = product[31:0].
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (rt_val=0, either signedness): lo=all ones, hi=rs_val unmodified. Latency unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy: ignored; no queueing.
- start and mthi_we/mtlo_we in the same IDLE cycle: the MT write takes effect, then is overwritten at done.
- mthi_we/mtlo_we while busy: ignored. The hazard unit must not issue them while busy.
- Invalid op encodings: none, since all four 2-bit values are defined.
- rst asserted mid-operation: operation aborted, no done pulse, hi/lo=0 the following cycle.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- When defined:
  - MULT/MULTU compute the full 64-bit product in one cycle using a combinational multiplier. The state goes IDLE -> FIX directly, skipping CALC.
  - busy=1 in cycle T+1 only; done and new hi/lo in cycle T+2.
  - Divide is unchanged.
- When undefined: all ops use the iterative path with XLEN+2 latency, and no hardware multiplier is inferred.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, start at T -> busy T+1..T+33; done at T+34 with hi=0xFFFFFFFE, lo=0x00000001. With MULDIV_FAST_MUL_EN: done at T+2, same values.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. Both complete at T+34.
- Start DIVU at T, pulse start again with new operands at T+5, and assert mthi_we (wdata=0xAAAA5555) at T+6 -> single done at T+34 carrying the first operation's results; HI is not 0xAAAA5555. Then mtlo_we in IDLE with wdata=0x1234 -> lo=0x1234 next cycle.
- Start MULT at T, assert rst at T+10 -> busy=0, hi=lo=0 at T+11; no done pulse through T+40. A new start at T+12 completes normally at T+46.
